// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
//   Shared definitions for the game controller slice: the main FSM phase
//   encodings (also consumed by main_fsm), the default number of event
//   sources and the event scheduler state enum.
// ---------------------------------------------------------------------------
package game_pkg;

  // Main FSM phase encodings (3-bit)
  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_1       = 3'd1;
  localparam logic [2:0] PH_2       = 3'd2;
  localparam logic [2:0] PH_3       = 3'd3;
  localparam logic [2:0] PH_4       = 3'd4;
  localparam logic [2:0] PH_SUCCESS = 3'd5;
  localparam logic [2:0] PH_FAIL    = 3'd6;

  localparam int NUM_EVENTS_DEF = 4;

  typedef enum logic [1:0] {
    SCH_IDLE   = 2'd0,
    SCH_WAIT   = 2'd1,
    SCH_ACTIVE = 2'd2,
    SCH_COOL   = 2'd3
  } sched_state_e;

  // True for the four playable phases; events are only scheduled there.
  function automatic logic phase_running(input logic [2:0] ph);
    logic r;
    case (ph)
      PH_1, PH_2, PH_3, PH_4:           r = 1'b1;
      PH_IDLE, PH_SUCCESS, PH_FAIL:     r = 1'b0;
      default:                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/event_lfsr.sv
// ---------------------------------------------------------------------------
// event_lfsr
//   16-bit Galois LFSR (taps 16,14,13,11) used to jitter event timing and
//   event selection. Steps once per clock while en_i is high; resets to SEED.
//
// Ports:
//   clk     in  1   system clock
//   rst_n   in  1   asynchronous active-low reset
//   en_i    in  1   step enable
//   lfsr_o  out 16  current LFSR state
// ---------------------------------------------------------------------------
module event_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  // Right-shifting Galois form: feedback mask for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] TAP_MASK = 16'hB400;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAP_MASK : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/event_scheduler.sv
// ---------------------------------------------------------------------------
// event_scheduler
//   Issues timed hazard events to the puzzle/event modules while a game
//   phase runs. Waits a phase-dependent interval, raises a one-hot request,
//   waits a bounded window for the addressed source to resolve it, then
//   cools down before the next wait. Outcome is reported as 1-cycle pulses;
//   event_fail feeds the main FSM's stability counter.
//
//   State table:
//     SCH_IDLE   | no game phase running, outputs quiet
//     SCH_WAIT   | counting down the inter-event interval
//     SCH_ACTIVE | request raised, counting down the response window
//     SCH_COOL   | event closed, counting down before the next wait
//
// Ports:
//   clk           in  1        system clock
//   rst_n         in  1        asynchronous active-low reset
//   tick          in  1        time-base strobe (1 ms nominal)
//   phase         in  3        main FSM phase encoding
//   game_enable   in  1        high while a phase is active
//   event_ack     in  N        per-source resolve level (rising edge counts)
//   event_req     out N        one-hot request, zero when no event open
//   event_id      out log2(N)  current / most recent event index
//   event_active  out 1        high while an event is open
//   event_pass    out 1        pulse: event resolved
//   event_fail    out 1        pulse: response window expired
//   countdown     out CNT_W    remaining ticks in WAIT/ACTIVE/COOL
//
// Build option:
//   EVENT_SCHED_JITTER_EN  adds LFSR jitter to WAIT length and event choice.
// ---------------------------------------------------------------------------
module event_scheduler
  import game_pkg::*;
#(
  parameter int NUM_EVENTS    = NUM_EVENTS_DEF,
  parameter int BASE_INTERVAL = 2000,
  parameter int RESP_WINDOW   = 1500,
  parameter int COOLDOWN      = 500,
  parameter int CNT_W         = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tick,
  input  logic [2:0]                    phase,
  input  logic                          game_enable,
  input  logic [NUM_EVENTS-1:0]         event_ack,
  output logic [NUM_EVENTS-1:0]         event_req,
  output logic [$clog2(NUM_EVENTS)-1:0] event_id,
  output logic                          event_active,
  output logic                          event_pass,
  output logic                          event_fail,
  output logic [CNT_W-1:0]              countdown
);

  localparam int IDW = $clog2(NUM_EVENTS);

  localparam logic [CNT_W-1:0] BASE_LD = CNT_W'(BASE_INTERVAL);
  localparam logic [CNT_W-1:0] RESP_LD = CNT_W'(RESP_WINDOW);
  localparam logic [CNT_W-1:0] COOL_LD = CNT_W'(COOLDOWN);
  localparam logic [NUM_EVENTS-1:0] ONE_HOT0 = NUM_EVENTS'(1);

  // A load of zero would never expire; run it as a single tick instead.
  function automatic logic [CNT_W-1:0] clamp1(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_EVENTS-1:0] req_q, req_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic [NUM_EVENTS-1:0] ack_q;

  logic                  run;
  logic                  expire;
  logic                  ack_edge;
  logic [CNT_W-1:0]      jitter;
  logic [IDW-1:0]        pick;
  logic [CNT_W-1:0]      wait_ld;

`ifdef EVENT_SCHED_JITTER_EN
  logic [15:0] lfsr;

  event_lfsr #(
    .SEED (16'hACE1)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (1'b1),
    .lfsr_o (lfsr)
  );

  assign jitter = CNT_W'(lfsr[6:0]);
  // Never repeat the previous event back to back.
  assign pick   = (lfsr[IDW-1:0] == id_q) ? (lfsr[IDW-1:0] + 1'b1) : lfsr[IDW-1:0];
`else
  assign jitter = '0;
  assign pick   = ptr_q;
`endif

  assign run      = game_enable & phase_running(phase);
  assign expire   = tick & (cnt_q == CNT_W'(1));
  assign ack_edge = event_ack[id_q] & ~ack_q[id_q];
  // Phase is sampled here at load time; later phase changes wait for the next load.
  assign wait_ld  = clamp1((BASE_LD >> (phase - 3'd1)) + jitter);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;

    if (!run) begin
      state_d = SCH_IDLE;
      cnt_d   = '0;
      req_d   = '0;
    end else begin
      case (state_q)
        SCH_IDLE: begin
          state_d = SCH_WAIT;
          cnt_d   = wait_ld;
        end
        SCH_WAIT: begin
          if (expire) begin
            state_d = SCH_ACTIVE;
            cnt_d   = clamp1(RESP_LD);
            id_d    = pick;
            req_d   = ONE_HOT0 << pick;
            ptr_d   = ptr_q + 1'b1;
          end else if (tick) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SCH_ACTIVE: begin
          // Ack is checked first so it wins over a coincident expiry.
          if (ack_edge) begin
            state_d = SCH_COOL;
            cnt_d   = clamp1(COOL_LD);
            req_d   = '0;
            pass_d  = 1'b1;
          end else if (expire) begin
            state_d = SCH_COOL;
            cnt_d   = clamp1(COOL_LD);
            req_d   = '0;
            fail_d  = 1'b1;
          end else if (tick) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        SCH_COOL: begin
          if (expire) begin
            state_d = SCH_WAIT;
            cnt_d   = wait_ld;
          end else if (tick) begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = SCH_IDLE;
          cnt_d   = '0;
          req_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCH_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      // Sampled in every state so a level already high at request time is not an edge.
      ack_q   <= event_ack;
    end
  end

  assign event_req    = req_q;
  assign event_id     = id_q;
  assign event_active = (state_q == SCH_ACTIVE);
  assign event_pass   = pass_q;
  assign event_fail   = fail_q;
  assign countdown    = cnt_q;

endmodule

// File: tb/tb_event_scheduler.sv
module tb_event_scheduler;

  localparam int N    = 4;
  localparam int BASE = 2000;
  localparam int RESP = 1500;
  localparam int COOL = 500;
  localparam int CW   = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic [2:0]    phase = 3'd0;
  logic          game_enable = 1'b0;
  logic [N-1:0]  event_ack = '0;
  logic [N-1:0]  event_req;
  logic [1:0]    event_id;
  logic          event_active;
  logic          event_pass;
  logic          event_fail;
  logic [CW-1:0] countdown;

  event_scheduler #(
    .NUM_EVENTS    (N),
    .BASE_INTERVAL (BASE),
    .RESP_WINDOW   (RESP),
    .COOLDOWN      (COOL),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .phase        (phase),
    .game_enable  (game_enable),
    .event_ack    (event_ack),
    .event_req    (event_req),
    .event_id     (event_id),
    .event_active (event_active),
    .event_pass   (event_pass),
    .event_fail   (event_fail),
    .countdown    (countdown)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 waiting, 2 event open, 3 cooling; rem = ticks left
  int           m_mode, m_rem, m_next, m_id;
  bit           m_pass, m_fail;
  logic [N-1:0] m_prev;

  function automatic int interval(input int ph);
    int v;
    v = BASE / (1 << (ph - 1));
    return (v == 0) ? 1 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit run, acked;
    if (!rst_n) begin
      m_mode = 0; m_rem = 0; m_next = 0; m_id = 0;
      m_pass = 0; m_fail = 0; m_prev = '0;
    end else begin
      run   = game_enable && (phase >= 1) && (phase <= 4);
      acked = event_ack[m_id] && !m_prev[m_id];
      m_pass = 0;
      m_fail = 0;
      if (!run) begin
        m_mode = 0;
        m_rem  = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
        m_rem  = interval(phase);
      end else if (m_mode == 2 && acked) begin
        m_pass = 1;
        m_mode = 3;
        m_rem  = COOL;
      end else if (tick) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          if (m_mode == 1) begin
            m_mode = 2;
            m_id   = m_next;
            m_next = (m_next + 1) % N;
            m_rem  = RESP;
          end else if (m_mode == 2) begin
            m_fail = 1;
            m_mode = 3;
            m_rem  = COOL;
          end else begin
            m_mode = 1;
            m_rem  = interval(phase);
          end
        end
      end
      m_prev = event_ack;
    end
  end

  always @(negedge clk) begin : compare
    logic [20:0] exp_v;
    if (chk_on) begin
      exp_v = {((m_mode == 2) ? N'(1 << m_id) : N'(0)), 2'(m_id), (m_mode == 2),
               m_pass, m_fail, CW'(m_rem)};
      check("cycle_outputs",
            {event_req, event_id, event_active, event_pass, event_fail, countdown}, exp_v);
    end
  end

  // which: 0 request raised, 1 pass pulse, 2 fail pulse, 3 open event at countdown 1
  task automatic wait_for(input int which, input int budget, output int n, output bit saw_pass);
    bit hit;
    n = 0;
    saw_pass = 0;
    forever begin
      @(negedge clk);
      n++;
      if (event_pass) saw_pass = 1;
      hit = (which == 0 && event_req != '0) || (which == 1 && event_pass) ||
            (which == 2 && event_fail) || (which == 3 && event_active && countdown == CW'(1));
      if (hit) break;
      if (n >= budget) begin
        tests++;
        fails++;
        $display("FAIL wait_%0d: condition not seen after %0d cycles", which, n);
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    bit sp;

    #12;
    check("reset_outputs", {event_req, event_id, event_active, event_pass, event_fail, countdown}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    tick = 1'b1;

    // Default flow, phase 1
    phase = 3'd1;
    game_enable = 1'b1;
    wait_for(0, 3000, n, sp);
    check("p1_wait_cycles", n, 2001);
    check("p1_req", event_req, 4'b0001);
    check("p1_countdown", countdown, 1500);
    repeat (99) @(negedge clk);
    event_ack[0] = 1'b1;
    @(negedge clk);
    check("p1_pass", event_pass, 1);
    check("p1_req_clear", event_req, 0);
    check("p1_cool_load", countdown, 500);
    event_ack[0] = 1'b0;
    wait_for(0, 3000, n, sp);
    check("p1_next_cycles", n, 2500);
    check("p1_next_req", event_req, 4'b0010);
    check("p1_next_id", event_id, 1);

    // Abort mid-event
    repeat (10) @(negedge clk);
    game_enable = 1'b0;
    @(negedge clk);
    check("abort_quiet", {event_req, event_active, event_pass, event_fail, countdown}, 0);
    check("abort_id_kept", event_id, 1);

    // Async reset mid-wait
    phase = 3'd2;
    game_enable = 1'b1;
    repeat (50) @(negedge clk);
    check("p2_wait_count", countdown, 951);
    #2 rst_n = 1'b0;
    #1 check("async_reset", {event_req, event_id, event_active, event_pass, event_fail, countdown}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Timeout, phase 2
    wait_for(0, 2000, n, sp);
    check("p2_wait_cycles", n, 1001);
    check("p2_req", event_req, 4'b0001);
    wait_for(2, 2000, n, sp);
    check("p2_fail_cycles", n, 1500);
    check("p2_no_pass", sp, 0);
    wait_for(0, 2000, n, sp);
    check("p2_next_cycles", n, 1500);
    check("p2_next_id", event_id, 1);

    // Wrong and stale acks, phase 4
    phase = 3'd4;
    event_ack[1] = 1'b1;
    @(negedge clk);
    check("p4_pass_id1", event_pass, 1);
    event_ack[1] = 1'b0;
    wait_for(0, 1000, n, sp);
    check("p4_wait_cycles", n, 750);
    check("p4_req_id2", event_req, 4'b0100);
    event_ack[2] = 1'b1;
    @(negedge clk);
    check("p4_pass_id2", event_pass, 1);
    event_ack[2] = 1'b0;
    event_ack[3] = 1'b1;
    wait_for(0, 1000, n, sp);
    check("p4_req_id3", event_req, 4'b1000);
    repeat (20) @(negedge clk);
    event_ack[1] = 1'b1;
    @(negedge clk);
    event_ack[1] = 1'b0;
    wait_for(2, 2000, n, sp);
    check("stale_fail_cycles", n, 1479);
    check("stale_no_pass", sp, 0);
    event_ack[3] = 1'b0;

    // Ack on the expiring tick
    wait_for(3, 3000, n, sp);
    check("sim_id", event_id, 0);
    event_ack[0] = 1'b1;
    @(negedge clk);
    check("sim_pulses", {event_pass, event_fail}, 2'b10);
    event_ack[0] = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_scheduler.md
# event_scheduler

Issues timed hazard events to the puzzle/event modules while a game phase is running. The block waits a phase-dependent interval, raises a one-hot request to one event source, and waits a bounded window for that source to report resolution. It reports the outcome as single-cycle pulses; `event_fail` drives the `event_fail` input of the main game FSM, where it costs one stability point. The block sits between the main FSM, which supplies `phase` and `game_enable`, and the per-event puzzle modules.

## Interface
Parameters:
- `NUM_EVENTS`, 4 — number of event sources; must be a power of 2, range 2..8.
- `BASE_INTERVAL`, 2000 — idle ticks before an event in phase 1.
- `RESP_WINDOW`, 1500 — ticks allowed to resolve an event.
- `COOLDOWN`, 500 — ticks after an event before the next wait starts.
- `CNT_W`, 12 — tick counter width; every tick parameter must fit in it.

Ports:
- `clk` in 1 — system clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `tick` in 1 — time-base strobe, one cycle wide (1 ms nominal).
- `phase` in 3 — main FSM state encoding: 0 IDLE, 1–4 PHASE1–4, 5 SUCCESS, 6 FAIL.
- `game_enable` in 1 — high while a phase is active.
- `event_ack` in NUM_EVENTS — level from each source; a rising edge means "resolved".
- `event_req` out NUM_EVENTS — one-hot request; all zero when no event is open.
- `event_id` out clog2(NUM_EVENTS) — index of the current or most recent event.
- `event_active` out 1 — high in ACTIVE.
- `event_pass` out 1 — 1-cycle pulse when an event is resolved.
- `event_fail` out 1 — 1-cycle pulse when the response window expires.
- `countdown` out CNT_W — remaining ticks in the current WAIT/ACTIVE/COOL state; 0 in IDLE.

## Operation
States:
- IDLE → WAIT when `game_enable`=1 and `phase` is 1–4.
- WAIT: on expiry → ACTIVE.
- ACTIVE: on ack edge → COOL with an `event_pass` pulse; on expiry → COOL with an `event_fail` pulse.
- COOL: on expiry → WAIT.

Loading:
- On entry to WAIT, the counter loads `BASE_INTERVAL >> (phase-1)`. With defaults this gives 2000/1000/500/250 ticks for phases 1–4. The value is sampled at load time, so a phase change mid-wait applies from the next WAIT.
- On entry to ACTIVE, the counter loads `RESP_WINDOW`, and `event_req` goes to one-hot at `event_id`.
- On entry to COOL, the counter loads `COOLDOWN`, and `event_req` clears.

Counter rules:
- The counter decrements on each `tick`.
- Expiry is a `tick` arriving while the counter equals 1, so a load of N lasts exactly N ticks.
- A loaded value of 0 is treated as 1.

Event selection:
- A round-robin pointer starts at 0 and becomes `event_id` on WAIT→ACTIVE. It then increments modulo NUM_EVENTS.

Ack detection:
- A registered copy of `event_ack` provides edge detection.
- Only a rising edge on `event_ack[event_id]` counts. Edges on other bits, or edges outside ACTIVE, are ignored.
- Edge-detect registers update in every state, so an ack level already high at request time does not count.

Boundary conditions:
- Ack edge and expiry in the same cycle: ack wins, giving `event_pass`, no `event_fail`.
- `game_enable` falls, or `phase` leaves 1–4, in any state: go to IDLE next cycle. Clear `event_req` and `countdown`. No pulse is emitted.
- The round-robin pointer is kept across IDLE and reset only by `rst_n`.
- `event_pass` and `event_fail` are never high together. At most one of them fires per event.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `event_req` 0, `event_id` 0, `event_active` 0, `event_pass` 0, `event_fail` 0, `countdown` 0; pointer 0; edge registers 0.
- IDLE→WAIT: one cycle after the enable condition is sampled.
- Expiring tick at cycle k: the new state, `event_req`, `countdown` and pulse are visible at k+1.
- Ack sampled high at cycle k (previous sample low): `event_pass` is high at k+1, and `event_req` is 0 at k+1.
- `rst_n` assertion mid-event clears everything asynchronously. No pulse is generated.

## Configuration
`EVENT_SCHED_JITTER_EN`:
- Defined: compiles in a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1) that steps every cycle.
  - The WAIT load becomes the phase interval plus `lfsr[6:0]` (0–127 extra ticks).
  - `event_id` on WAIT→ACTIVE comes from `lfsr` low bits instead of the round-robin pointer. If that index equals the previous `event_id`, it is incremented by 1 modulo NUM_EVENTS.
- Undefined: no LFSR; the behaviour is fully deterministic as described in Operation.

## Structure
- Shared package `game_pkg`: phase encodings (IDLE..FAIL, 3-bit), default NUM_EVENTS, and the scheduler state enum. `main_fsm` uses the same phase constants.
- One sub-module: `event_lfsr` (16-bit LFSR with enable and seed), instantiated only under `EVENT_SCHED_JITTER_EN`.

## Test plan
- **Default flow.** Reset, then phase=1 and `game_enable`=1 with `tick` every cycle. Expect `event_req`=4'b0001 exactly 2000 ticks after WAIT entry and `countdown`=1500. Pulse `event_ack[0]` at tick 100 → `event_pass` for 1 cycle, `event_req`=0, COOL for 500 ticks, then the next request is 4'b0010.
- **Timeout.** Phase=2, no ack. Expect a request after 1000 ticks, `event_fail` pulse 1500 ticks later, never `event_pass`, and `event_id`=1 on the next event.
- **Wrong and stale ack.** Hold `event_ack[3]`=1 before the request for `event_id`=3, and pulse `event_ack[1]` while `event_id`=3. Expect no pass; the window expires with `event_fail`.
- **Simultaneous.** An ack edge and the expiring tick in the same cycle → `event_pass`=1, `event_fail`=0.
- **Abort.** Drop `game_enable` mid-ACTIVE → IDLE next cycle, `event_req`=0, `countdown`=0, no pulse. Assert `rst_n` low mid-WAIT → all outputs 0 immediately.
- **Jitter build** (macro defined). Across 64 events, WAIT lengths fall within [interval, interval+127] and no two consecutive `event_id`s are equal.
